ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Round-robin arbiter that shares one port of the multiport dynamic RAM between several requesters (fetch, load/store, DMA-style masters). It registers one request per cycle onto the RAM port's address/data/write lines. It returns read data to the winning requester with a fixed latency. It sits between the processor-side masters and a single `address`/`datain`/`dataout`/`mem_write` slice of the RAM.

## Interface
Parameters:
- `requester_count`, 4, number of requesters (2..8)
- `addr_width`, 12, RAM address width
- `mem_width`, 12, RAM word width
- `max_burst`, 4, maximum consecutive grants to one requester (used only with burst enabled)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `req`  in  requester_count  request per requester; held until granted
- `we`  in  requester_count  1 = write, 0 = read, per requester
- `addr`  in  addr_width*requester_count  packed addresses, requester i at [i*addr_width +: addr_width]
- `wdata`  in  mem_width*requester_count  packed write data, same packing
- `gnt`  out  requester_count  one-hot; pulse = request accepted
- `rvalid`  out  requester_count  one-hot; pulse = `rdata` valid for that requester
- `rdata`  out  mem_width  read data, shared by all requesters
- `ram_address`  out  addr_width  to RAM port address slice
- `ram_datain`  out  mem_width  to RAM port datain slice
- `ram_mem_write`  out  1  to RAM port mem_write bit
- `ram_dataout`  in  mem_width  from RAM port dataout slice

## Operation
- FSM states:
  - IDLE: no grant last cycle.
  - GRANT: a grant was issued last cycle.
- Transitions:
  - Any `req` bit set at an edge → GRANT.
  - No `req` bit set → IDLE.
- Arbitration at each edge, over the sampled `req` vector:
  - A `last` pointer holds the most recently granted index.
  - Search starts at `last+1` and wraps modulo `requester_count`.
  - The first set bit wins. `last` and `gnt` update to the winner.
- On a win, the winner's `addr`, `wdata` and `we` are registered into `ram_address`, `ram_datain` and `ram_mem_write`.
- On IDLE, `ram_mem_write` = 0; `ram_address` and `ram_datain` hold their previous values.
- Read return:
  - A read grant is queued into a 2-stage shift register of one-hot requester IDs.
  - Stage 2 drives `rvalid`.
  - `rdata` = `ram_dataout`, passed through combinationally.
- Writes produce no `rvalid`.
- Requester rule: when it sees its `gnt` bit high, it drops `req` or presents its next operation during that same cycle. A still-asserted `req` is a new request.
- Reset (`reset` = 0 at an edge):
  - `gnt`, `rvalid`, `ram_mem_write`, `ram_address` and `ram_datain` go to 0.
  - `last` goes to `requester_count-1`, so requester 0 has first priority.
  - The pipeline is flushed; in-flight reads are dropped with no `rvalid`.
  - Burst counter goes to 0. FSM goes to IDLE.

## Timing
- Cycle t: requester i asserts `req[i]`.
- Edge ending t: the arbiter samples `req[i]`.
- Cycle t+1: `gnt[i]` = 1 and the RAM port lines carry the operation.
- Edge ending t+1: the RAM captures the write, or its registered read.
- Cycle t+2: for a read, `rvalid[i]` = 1 and `rdata` is valid.
- Throughput: one RAM access per cycle. Back-to-back reads from different requesters return in grant order.
- Single requester, no burst: re-granted every cycle while `req` stays high and no other requester is pending.
- Write followed by a read to the same address on the next grant returns the new data. This relies on the RAM's write-then-read ordering.

## Configuration
- `RAM_ARB_BURST_EN` defined:
  - While `req[last]` stays high, `last` keeps the grant, up to `max_burst` consecutive grants.
  - A burst counter tracks the run. It resets to 1 when the grant switches requester.
  - When the counter reaches `max_burst`, `last` is skipped and normal rotation applies for one arbitration.
  - If no one else requests, the counter restarts.
- `RAM_ARB_BURST_EN` undefined:
  - Strict round robin; `last` always has lowest priority.
  - No counter logic is compiled in, and `max_burst` is ignored.

## Test plan
- Reset, then `req`=4'b0001, `we[0]`=1, `addr0`=12'h004, `wdata0`=12'hABC → next cycle `gnt`=4'b0001, `ram_mem_write`=1, `ram_address`=12'h004, `ram_datain`=12'hABC; `rvalid` stays 0.
- After that write, requester 2 reads 12'h004 → `gnt[2]` one cycle after `req`; `rvalid`=4'b0100 with `rdata`=12'hABC two cycles after `req`.
- All four requesters hold `req` continuously (burst off) → `gnt` sequence 0001, 0010, 0100, 1000, 0001.
- Burst on, `max_burst`=4, `req`=4'b0011 held → `gnt` shows 0001 four times, then 0010 four times, then 0001 again.
- Read granted, then `reset` low for one edge in the following cycle → no `rvalid` appears; all outputs are 0; the first grant after release goes to requester 0 when `req`=4'b1111.
- `req`=0 for 3 cycles → `gnt`=0 and `ram_mem_write`=0; `ram_address` keeps its last value.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among several requesters, with a fixed two-cycle read return.
// Optional burst mode (sticky grants up to max_burst) is compiled in when RAM_ARB_BURST_EN is defined.
module ram_port_arbiter #(
    parameter int requester_count = 4,
    parameter int addr_width      = 12,
    parameter int mem_width       = 12,
    parameter int max_burst       = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [requester_count-1:0]            req,
    input  logic [requester_count-1:0]            we,
    input  logic [addr_width*requester_count-1:0] addr,
    input  logic [mem_width*requester_count-1:0]  wdata,
    output logic [requester_count-1:0]            gnt,
    output logic [requester_count-1:0]            rvalid,
    output logic [mem_width-1:0]                  rdata,
    output logic [addr_width-1:0]                 ram_address,
    output logic [mem_width-1:0]                  ram_datain,
    output logic                                  ram_mem_write,
    input  logic [mem_width-1:0]                  ram_dataout
);

    localparam int idx_w = (requester_count > 1) ? $clog2(requester_count) : 1;

    if (requester_count < 2 || requester_count > 8 || max_burst < 1) begin : g_bad_cfg
        $error("ram_port_arbiter: unsupported parameter combination");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                     state_reg, state_next;
    logic [idx_w-1:0]           last_reg, last_next;
    logic [addr_width-1:0]      addr_reg, addr_next;
    logic [mem_width-1:0]       din_reg, din_next;
    logic                       wr_reg, wr_next;
    logic [requester_count-1:0] rd_stage1_reg, rd_stage1_next;
    logic [requester_count-1:0] rd_stage2_reg;

    logic [addr_width-1:0]      addr_arr  [requester_count];
    logic [mem_width-1:0]       wdata_arr [requester_count];

    logic                       win_valid;
    logic [idx_w-1:0]           win_idx;
    logic                       sel_valid;
    logic [idx_w-1:0]           sel_idx;
    logic [requester_count-1:0] sel_onehot;

    for (genvar gi = 0; gi < requester_count; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*addr_width +: addr_width];
        assign wdata_arr[gi] = wdata[gi*mem_width +: mem_width];
    end

    // Walk from farthest to nearest so the first set bit after last wins.
    always_comb begin
        int cand;
        win_valid = 1'b0;
        win_idx   = last_reg;
        for (int k = requester_count; k >= 1; k--) begin
            cand = (int'(last_reg) + k) % requester_count;
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = idx_w'(cand);
            end
        end
    end

`ifdef RAM_ARB_BURST_EN
    localparam int              cnt_w       = $clog2(max_burst + 1);
    localparam logic [cnt_w-1:0] burst_limit = cnt_w'(max_burst);

    logic [cnt_w-1:0] burst_cnt_reg, burst_cnt_next;
    logic             hold;

    // A zero count (after reset) means no run is in progress, so rotation applies.
    assign hold      = req[last_reg] && (burst_cnt_reg != '0) && (burst_cnt_reg < burst_limit);
    assign sel_valid = hold | win_valid;
    assign sel_idx   = hold ? last_reg : win_idx;

    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (sel_valid) begin
            burst_cnt_next = hold ? burst_cnt_reg + 1'b1 : cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt_reg <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    assign sel_valid = win_valid;
    assign sel_idx   = win_idx;
`endif

    always_comb begin
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
    end

    always_comb begin
        state_next     = IDLE;
        last_next      = last_reg;
        addr_next      = addr_reg;
        din_next       = din_reg;
        wr_next        = 1'b0;
        rd_stage1_next = '0;
        if (sel_valid) begin
            state_next = GRANT;
            last_next  = sel_idx;
            addr_next  = addr_arr[sel_idx];
            din_next   = wdata_arr[sel_idx];
            wr_next    = we[sel_idx];
            if (!we[sel_idx]) begin
                rd_stage1_next = sel_onehot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            last_reg      <= idx_w'(requester_count - 1);
            addr_reg      <= '0;
            din_reg       <= '0;
            wr_reg        <= 1'b0;
            rd_stage1_reg <= '0;
            rd_stage2_reg <= '0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            addr_reg      <= addr_next;
            din_reg       <= din_next;
            wr_reg        <= wr_next;
            rd_stage1_reg <= rd_stage1_next;
            rd_stage2_reg <= rd_stage1_reg;
        end
    end

    // The grant is the last pointer, shown only in the cycle after a win.
    always_comb begin
        gnt = '0;
        if (state_reg == GRANT) begin
            gnt[last_reg] = 1'b1;
        end
    end

    assign rvalid        = rd_stage2_reg;
    assign rdata         = ram_dataout;
    assign ram_address   = addr_reg;
    assign ram_datain    = din_reg;
    assign ram_mem_write = wr_reg;

endmodule
